// File: rtl/tl_cntr_timed.sv
// rtl/tl_cntr_timed.sv - timer-driven two-road traffic light with protected-left phases
// Optional pedestrian walk phase is built when TL_PED_EN is defined.
module tl_cntr_timed #(
  parameter int YELLOW_CYC    = 2,
  parameter int ALL_RED_CYC   = 1,
  parameter int MIN_GREEN_CYC = 3,
  parameter int MAX_GREEN_CYC = 8,
  parameter int PED_CYC       = 4,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       Ta,
  input  logic       Tal,
  input  logic       Tb,
  input  logic       Tbl,
`ifdef TL_PED_EN
  input  logic       ped_req,
  output logic       walk,
`endif
  output logic [1:0] La,
  output logic [1:0] Lb
);

  localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] RED_LAST = CNT_W'(ALL_RED_CYC - 1);
  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] PED_LAST = CNT_W'(PED_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [3:0] {
    A_GRN, A_YEL, A_LFT, A_LYL, RED_A,
    B_GRN, B_YEL, B_LFT, B_LYL, RED_B
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             ped_phase;
  logic             ped_dem;
  logic             min_ok;
  logic             max_ok;
  logic             yel_done;
  logic             red_done;

`ifdef TL_PED_EN
  logic pending;
  logic enter_red;
  assign ped_phase = walk;
  assign ped_dem   = pending;
  assign enter_red = (state_nxt != state) && (state_nxt == RED_A || state_nxt == RED_B);
`else
  assign ped_phase = 1'b0;
  assign ped_dem   = 1'b0;
`endif

  assign min_ok   = cnt >= MIN_LAST;
  assign max_ok   = cnt >= MAX_LAST;
  assign yel_done = cnt >= YEL_LAST;
  assign red_done = cnt >= (ped_phase ? PED_LAST : RED_LAST);

  // Own left sensor counts as conflicting demand: it needs the road to leave through green.
  always_comb begin
    state_nxt = state;
    case (state)
      A_GRN: if (min_ok && (Tb | Tbl | Tal | ped_dem) && (!Ta || max_ok)) state_nxt = A_YEL;
      A_YEL: if (yel_done) state_nxt = Tal ? A_LFT : RED_A;
      A_LFT: if (min_ok && (!Tal || max_ok)) state_nxt = A_LYL;
      A_LYL: if (yel_done) state_nxt = RED_A;
      RED_A: if (red_done) state_nxt = B_GRN;
      B_GRN: if (min_ok && (Ta | Tal | Tbl | ped_dem) && (!Tb || max_ok)) state_nxt = B_YEL;
      B_YEL: if (yel_done) state_nxt = Tbl ? B_LFT : RED_B;
      B_LFT: if (min_ok && (!Tbl || max_ok)) state_nxt = B_LYL;
      B_LYL: if (yel_done) state_nxt = RED_B;
      RED_B: if (red_done) state_nxt = A_GRN;
      default: state_nxt = RED_B;
    endcase
  end

  function automatic logic [1:0] lamp_of(input state_t s, input state_t grn, input state_t yel,
                                         input state_t lft, input state_t lyl);
    logic [1:0] l;
    if (s == grn)                   l = 2'b00;
    else if (s == yel || s == lyl)  l = 2'b01;
    else if (s == lft)              l = 2'b11;
    else                            l = 2'b10;
    return l;
  endfunction

  // Lamps decode the next state so they change on the edge that enters it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RED_B;
      cnt   <= '0;
      La    <= 2'b10;
      Lb    <= 2'b10;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) cnt <= '0;
      else if (cnt != '1)     cnt <= cnt + CNT_ONE;
      La <= lamp_of(state_nxt, A_GRN, A_YEL, A_LFT, A_LYL);
      Lb <= lamp_of(state_nxt, B_GRN, B_YEL, B_LFT, B_LYL);
    end
  end

`ifdef TL_PED_EN
  // A request on the entry edge itself re-arms pending for the following red.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= 1'b0;
      walk    <= 1'b0;
    end else begin
      if (enter_red)               walk <= pending;
      else if (state_nxt != state) walk <= 1'b0;
      pending <= ped_req | (pending & ~enter_red);
    end
  end
`endif

endmodule
